// File: rtl/prototype.sv
// rtl/prototype.sv - sequential shift-and-add sparse ternary multiply prototype
module prototype #(
  parameter int WIDTH  = 16,
  parameter int N_COEF = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_poly_a,
  input  logic [2*N_COEF-1:0]   i_poly_r,
  output logic [WIDTH-1:0]      r_sum_one,
  output logic [WIDTH-1:0]      r_sum_mone,
  output logic                  o_done
);

  // Index must address every coefficient; keep at least one bit for N_COEF == 1.
  localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

  // Coefficient codes; 2'b10 is reserved and contributes nothing.
  localparam logic [1:0] COEF_PLUS  = 2'b01;
  localparam logic [1:0] COEF_MINUS = 2'b11;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      index, index_next;
  logic [WIDTH-1:0]      a_reg, a_next;
  logic [2*N_COEF-1:0]   r_reg, r_next;
  logic [WIDTH-1:0]      one_next, mone_next;
  logic                  done_next;

  // Current coefficient and the shifted operand it would contribute.
  logic [2*N_COEF-1:0]   r_aligned;
  logic [1:0]            coef;
  logic [WIDTH-1:0]      a_shifted;

  // Select coefficient `index` and form a << index, dropping bits above WIDTH-1.
  always_comb begin
    r_aligned = r_reg >> {index, 1'b0};
    coef      = r_aligned[1:0];
    a_shifted = a_reg << index;
  end

  // State, shadow and accumulator registers; everything clears on async reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= LOAD;
      index      <= '0;
      a_reg      <= '0;
      r_reg      <= '0;
      r_sum_one  <= '0;
      r_sum_mone <= '0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      a_reg      <= a_next;
      r_reg      <= r_next;
      r_sum_one  <= one_next;
      r_sum_mone <= mone_next;
      o_done     <= done_next;
    end
  end

  // Next-state and datapath: capture once, then one coefficient per edge, then hold.
  always_comb begin
    state_next = state;
    index_next = index;
    a_next     = a_reg;
    r_next     = r_reg;
    one_next   = r_sum_one;
    mone_next  = r_sum_mone;
    done_next  = o_done;

    case (state)
      LOAD: begin
        a_next     = i_poly_a;
        r_next     = i_poly_r;
        one_next   = '0;
        mone_next  = '0;
        index_next = '0;
        state_next = RUN;
      end

      RUN: begin
        if (coef == COEF_PLUS) begin
          one_next = r_sum_one + a_shifted;
        end else if (coef == COEF_MINUS) begin
          mone_next = r_sum_mone + a_shifted;
        end
        index_next = index + 1'b1;
        if (index == LAST_IDX) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end

      DONE: begin
        // Result is final; only reset restarts the operation.
      end

      default: begin
        state_next = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_prototype.sv
// tb/tb_prototype.sv - directed self-checking bench for prototype
module tb_prototype;

  logic        i_clock;
  logic        i_reset;
  logic [15:0] i_poly_a;
  logic [15:0] i_poly_r;
  logic [15:0] r_sum_one;
  logic [15:0] r_sum_mone;
  logic        o_done;

  int checks;
  int errors;

  prototype #(.WIDTH(16), .N_COEF(8)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_poly_a  (i_poly_a),
    .i_poly_r  (i_poly_r),
    .r_sum_one (r_sum_one),
    .r_sum_mone(r_sum_mone),
    .o_done    (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Hold reset, present inputs, check the reset state, release on a falling edge.
  task automatic start(input logic [15:0] a, input logic [15:0] r, input string tag);
    i_reset  = 1'b0;
    i_poly_a = a;
    i_poly_r = r;
    @(negedge i_clock);
    check({tag, "_rst_one"},  r_sum_one, 16'h0000);
    check({tag, "_rst_mone"}, r_sum_mone, 16'h0000);
    check({tag, "_rst_done"}, {15'd0, o_done}, 16'h0000);
    i_reset = 1'b1;
  endtask

  // Advance n rising edges, ending on a falling edge so outputs are stable.
  task automatic edges(input int n);
    repeat (n) @(negedge i_clock);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    i_reset  = 1'b0;
    i_poly_a = '0;
    i_poly_r = '0;

    // Case 1: a=1, r=1
    start(16'h0001, 16'h0001, "c1");
    edges(1);
    check("c1_e1_one", r_sum_one, 16'h0000);
    edges(1);
    check("c1_e2_one", r_sum_one, 16'h0001);
    edges(6);
    check("c1_e8_done", {15'd0, o_done}, 16'h0000);
    edges(1);
    check("c1_e9_done", {15'd0, o_done}, 16'h0001);
    check("c1_one", r_sum_one, 16'h0001);
    check("c1_mone", r_sum_mone, 16'h0000);
    // DONE holds regardless of input changes
    i_poly_a = 16'hFFFF;
    i_poly_r = 16'hFFFF;
    edges(3);
    check("c1_hold_one", r_sum_one, 16'h0001);
    check("c1_hold_mone", r_sum_mone, 16'h0000);
    check("c1_hold_done", {15'd0, o_done}, 16'h0001);

    // Case 2: coefficient 0 = +1, coefficient 7 = -1
    start(16'h0003, 16'hC001, "c2");
    edges(9);
    check("c2_one", r_sum_one, 16'h0003);
    check("c2_mone", r_sum_mone, 16'h0180);
    check("c2_done", {15'd0, o_done}, 16'h0001);

    // Case 3: all +1 with wrap
    start(16'hFFFF, 16'h5555, "c3");
    edges(9);
    check("c3_one", r_sum_one, 16'hFF01);
    check("c3_mone", r_sum_mone, 16'h0000);

    // Case 4: all reserved codes, sums stay zero every edge
    start(16'h1234, 16'hAAAA, "c4");
    for (int i = 1; i <= 9; i++) begin
      edges(1);
      check($sformatf("c4_e%0d_one", i), r_sum_one, 16'h0000);
      check($sformatf("c4_e%0d_mone", i), r_sum_mone, 16'h0000);
    end
    check("c4_done", {15'd0, o_done}, 16'h0001);

    // Case 5: inputs change during RUN; captured values win
    start(16'h0005, 16'h00C1, "c5");
    edges(3);
    i_poly_a = 16'hFFFF;
    i_poly_r = 16'hFFFF;
    edges(6);
    check("c5_one", r_sum_one, 16'h0005);
    check("c5_mone", r_sum_mone, 16'h0028);
    check("c5_done", {15'd0, o_done}, 16'h0001);

    // Case 6: shifted operand drops its top bit
    start(16'h8001, 16'h0004, "c6");
    edges(9);
    check("c6_one", r_sum_one, 16'h0002);
    check("c6_mone", r_sum_mone, 16'h0000);

    // Case 7: asynchronous reset mid-RUN, then a full rerun
    start(16'h00FF, 16'h5555, "c7");
    edges(4);
    check("c7_mid_one", r_sum_one, 16'h06F9);
    #2;
    i_reset = 1'b0;
    #1;
    check("c7_async_one", r_sum_one, 16'h0000);
    check("c7_async_mone", r_sum_mone, 16'h0000);
    check("c7_async_done", {15'd0, o_done}, 16'h0000);
    start(16'h0002, 16'hFFFF, "c7b");
    edges(8);
    check("c7b_e8_done", {15'd0, o_done}, 16'h0000);
    edges(1);
    check("c7b_done", {15'd0, o_done}, 16'h0001);
    check("c7b_one", r_sum_one, 16'h0000);
    check("c7b_mone", r_sum_mone, 16'h01FE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prototype.md
Name: prototype

Overview:
- Sequential shift-and-add prototype of the sparse ternary multiply used in the LAC polynomial-multiplier datapath.
- Multiplies a 16-bit operand a by a ternary multiplier r of 8 coefficients, each in {-1, 0, +1}.
- The +1 and -1 contributions go into two separate accumulators. The caller forms the final result as sum_one - sum_mone.
- Single-shot: runs once after each reset release and pulses nothing. o_done is a level that stays high.

Parameters:
- WIDTH, 16, width of operand a and of both accumulators.
- N_COEF, 8, number of ternary coefficients in r. The r port width is 2*N_COEF.

Ports:
- i_clock, input, 1: single clock; all state updates on its rising edge.
- i_reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- i_poly_a, input, WIDTH: operand a, unsigned.
- i_poly_r, input, 2*N_COEF: ternary multiplier. Coefficient k sits in bits [2k+1:2k].
- r_sum_one, output, WIDTH: registered accumulator of the +1 contributions.
- r_sum_mone, output, WIDTH: registered accumulator of the -1 contributions.
- o_done, output, 1: registered level; high once all coefficients have been processed.

Behaviour:
- Coefficient encoding: 00 = 0, 01 = +1, 11 = -1, 10 = 0 (reserved, treated as zero; no error flag).
- Reset (i_reset = 0, asynchronous):
  - state = LOAD, r_sum_one = 0, r_sum_mone = 0, o_done = 0, index = 0.
  - Internal a/r shadow registers are cleared.
- States: LOAD -> RUN -> DONE. No other states.
- LOAD, first rising edge with i_reset = 1:
  - capture i_poly_a and i_poly_r into the shadow registers;
  - clear both sums; index = 0; go to RUN.
- RUN, one coefficient per edge, coefficient k = current index:
  - k = +1: r_sum_one <= r_sum_one + (a << k), truncated to WIDTH bits.
  - k = -1: r_sum_mone <= r_sum_mone + (a << k), truncated to WIDTH bits.
  - k = 0: sums unchanged.
  - index increments every edge.
  - On the edge that processes index N_COEF-1: go to DONE and set o_done = 1.
- DONE: sums and o_done hold indefinitely; inputs are ignored. Only reset restarts the operation.
- Latency: 1 load edge + N_COEF run edges. With defaults, o_done rises after the 9th rising edge following reset release.
- Outputs are the running accumulators and are observable while RUN is in progress. After the first RUN edge they already reflect coefficient 0.
- Input changes after the LOAD edge have no effect on the current operation.
- Arithmetic: unsigned modulo 2^WIDTH. Overflow wraps silently; the shifted a also drops bits above WIDTH-1.
- Final values:
  - r_sum_one = (a * P) mod 2^WIDTH, with P = sum of 2^k over all +1 coefficients.
  - r_sum_mone = (a * M) mod 2^WIDTH, with M = sum of 2^k over all -1 coefficients.
- Reset asserted mid-RUN or in DONE: immediate asynchronous return to the reset values. The operation restarts from LOAD after release.
- No handshake inputs. Start is implicit at reset release.

Test Plan:
- a = 0x0001, r = 0x0001, release reset:
  - r_sum_one = 1 after the 2nd edge;
  - final r_sum_one = 0x0001, r_sum_mone = 0x0000;
  - o_done high after the 9th edge.
- a = 0x0003, r = 0xC001 (coefficient 0 = +1, coefficient 7 = -1):
  - final r_sum_one = 0x0003, r_sum_mone = 0x0180.
- a = 0xFFFF, r = 0x5555 (all +1):
  - final r_sum_one = (0xFFFF * 0xFF) mod 2^16 = 0xFF01, r_sum_mone = 0; exercises wrap.
- a = 0x1234, r = 0xAAAA (all reserved "10"):
  - both sums stay 0 throughout; o_done high after the 9th edge.
- Change i_poly_a/i_poly_r during RUN:
  - results match the values captured at LOAD.
- Assert i_reset = 0 mid-RUN:
  - sums and o_done clear immediately, without waiting for a clock edge.
  - After release, a full 9-edge run completes with the new inputs.
